// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master between NREQ requesters.
// Every output is a register fed from the current state, so each output
// becomes visible one cycle after the FSM enters the state that drives it.
module spi_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int N_CS    = 4,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 1000,
  parameter int GAP_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       req_data,
  input  logic [SEL_W*NREQ-1:0]   req_sel,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [7:0]              rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    m_start,
  output logic [7:0]              m_data_in,
  output logic [N_CS-1:0]         m_cs,
  input  logic [7:0]              m_data_out,
  input  logic                    m_done
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP,
    ST_GAP
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner_q;
  logic [7:0]       data_q;
  logic [SEL_W-1:0] sel_q;
  logic [7:0]       resp_data_q;
  logic             resp_err_q;
  logic [15:0]      wait_cnt;
  logic [15:0]      gap_cnt;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [7:0]       pick_data;
  logic [SEL_W-1:0] pick_sel;
  logic             pick_bad;
  int               pick_cand;

  logic [N_CS-1:0]  cs_onehot;
  logic [NREQ-1:0]  winner_onehot;
  logic             done_hit;
  logic             timeout_hit;
  logic             gap_last;
  logic             in_txn;

  // Round-robin search starting at rr_ptr, plus the winner's byte and select
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_cand  = 0;
    pick_data  = '0;
    pick_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      pick_cand = int'(rr_ptr) + i;
      if (pick_cand >= NREQ) pick_cand = pick_cand - NREQ;
      if (!pick_found && req[IDX_W'(pick_cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(pick_cand);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        pick_data = req_data[8*i +: 8];
        pick_sel  = req_sel[SEL_W*i +: SEL_W];
      end
    end
    pick_bad = ({{(32-SEL_W){1'b0}}, pick_sel} >= 32'(N_CS));
  end

  // Decode the latched select and winner into one-hot vectors
  always_comb begin
    cs_onehot     = '0;
    winner_onehot = '0;
    for (int c = 0; c < N_CS; c++) begin
      cs_onehot[c] = ({{(32-SEL_W){1'b0}}, sel_q} == 32'(c));
    end
    for (int i = 0; i < NREQ; i++) begin
      winner_onehot[i] = (winner_q == IDX_W'(i));
    end
  end

  // Next-state logic; a completion in the timeout cycle still counts as success
  always_comb begin
    state_nx    = state;
    done_hit    = (state == ST_WAIT) && m_done;
    timeout_hit = (state == ST_WAIT) && (wait_cnt == 16'(TIMEOUT));
    gap_last    = (gap_cnt == 16'(GAP_CYC - 1));
    in_txn      = (state == ST_LAUNCH) || (state == ST_WAIT) || (state == ST_RESP);
    case (state)
      ST_IDLE:   if (pick_found) state_nx = pick_bad ? ST_RESP : ST_LAUNCH;
      ST_LAUNCH: state_nx = ST_WAIT;
      ST_WAIT:   if (done_hit || timeout_hit) state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_GAP;
      ST_GAP:    if (gap_last) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Request latching, watchdog and gap counters, response capture, pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      winner_q    <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            winner_q <= pick_idx;
            data_q   <= pick_data;
            sel_q    <= pick_sel;
            if (pick_bad) begin
              resp_data_q <= 8'h00;
              resp_err_q  <= 1'b1;
            end
          end
        end
        ST_LAUNCH: wait_cnt <= 16'd1;
        ST_WAIT: begin
          if (done_hit) begin
            resp_data_q <= m_data_out;
            resp_err_q  <= 1'b0;
          end else if (timeout_hit) begin
            resp_data_q <= 8'h00;
            resp_err_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          wait_cnt <= '0;
          gap_cnt  <= '0;
        end
        ST_GAP: begin
          if (gap_last) begin
            gap_cnt <= '0;
            if (int'(winner_q) == NREQ - 1) rr_ptr <= '0;
            else                            rr_ptr <= winner_q + IDX_W'(1);
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs derived from the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      m_start   <= 1'b0;
      m_data_in <= '0;
      m_cs      <= '0;
    end else begin
      busy      <= (state != ST_IDLE);
      m_start   <= (state == ST_LAUNCH);
      m_cs      <= in_txn ? cs_onehot : '0;
      gnt       <= in_txn ? winner_onehot : '0;
      rsp_valid <= (state == ST_RESP) ? winner_onehot : '0;
      if (state == ST_LAUNCH) m_data_in <= data_q;
      if (state == ST_RESP) begin
        rsp_data <= resp_data_q;
        rsp_err  <= resp_err_q;
      end
    end
  end

endmodule

// File: doc/spi_req_arbiter.md
# spi_req_arbiter

Round-robin scheduler that shares one `spi_master` between NREQ independent requesters. Each requester posts an 8-bit byte and a slave index. The arbiter grants one request at a time, drives the master's `start`/`data_in`/`cs`, and returns the received byte to the winner. A per-transaction watchdog and an enforced inter-transaction gap protect the bus. It sits between the client logic and the `spi_master` instance.

## Interface
- NREQ, 4, number of requesters
- N_CS, 4, number of slave selects (width of `m_cs`)
- SEL_W, 2, width of each requester's slave index
- TIMEOUT, 1000, max cycles in WAIT before abort (16-bit counter, must be 1..65535)
- GAP_CYC, 2, idle cycles with `m_cs`=0 between transactions (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  request level per requester
- req_data  in  8*NREQ  byte to send; requester i uses [8*i+7:8*i]
- req_sel  in  SEL_W*NREQ  slave index per requester
- gnt  out  NREQ  one-hot, high for the granted requester from LAUNCH through RESP
- rsp_valid  out  NREQ  one-cycle pulse to the granted requester
- rsp_data  out  8  received byte, valid with `rsp_valid`
- rsp_err  out  1  valid with `rsp_valid`: 1 = timeout or bad select
- busy  out  1  high in any state except IDLE
- m_start  out  1  start pulse to `spi_master`
- m_data_in  out  8  byte to `spi_master`
- m_cs  out  N_CS  one-hot active-high slave select to `spi_master`
- m_data_out  in  8  received byte from `spi_master`
- m_done  in  1  completion from `spi_master`

## Operation
- States:
  - IDLE
  - LAUNCH: 1 cycle
  - WAIT
  - RESP: 1 cycle
  - GAP: GAP_CYC cycles
- IDLE: if any `req` is high, pick the winner round-robin, starting from the requester after the last granted one. Latch its data and sel into internal registers, then go to LAUNCH. The pointer resets to 0, so requester 0 has first priority after reset.
- LAUNCH:
  - `m_start`=1, `m_data_in`=latched byte, `m_cs`=one-hot(latched sel), `gnt` bit set.
  - Next state is WAIT.
- Bad select: if latched sel ≥ N_CS, skip LAUNCH and WAIT. The transition is IDLE→RESP with `rsp_err`=1, `rsp_data`=0, and `m_start`/`m_cs` never asserted.
- WAIT:
  - `m_cs` and `gnt` are held; the timeout counter increments each cycle.
  - If `m_done`=1, capture `m_data_out` and go to RESP with err=0.
  - Else if counter = TIMEOUT, go to RESP with err=1 and data=0.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - `rsp_valid[winner]`=1, `rsp_data`/`rsp_err` driven, `m_cs` still held.
  - Next state is GAP.
- GAP: `m_cs`=0, `gnt`=0, count GAP_CYC cycles, then go to IDLE. The pointer advances to winner+1 (mod NREQ).
- `m_done` is ignored outside WAIT.
- `req` and its data/sel are sampled only in IDLE. Dropping `req` mid-transaction does not abort it; `rsp_valid` still pulses.
- A requester holds `req` until it sees its `rsp_valid`. If `req` is still high afterward, it is a new request.
- `rsp_data`/`rsp_err` hold their last values between pulses.
- Reset mid-operation: all state is cleared immediately (asynchronous). The in-flight transaction is dropped with no `rsp_valid`.

## Timing
- Reset values: `gnt`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, `m_start`=0, `m_data_in`=0, `m_cs`=0, state=IDLE, pointer=0, counters=0.
- `req` high at edge k (in IDLE) → `m_start` high for exactly the cycle after edge k+1 (LAUNCH).
- `m_done` sampled high at edge j in WAIT → `rsp_valid` high for the cycle after edge j+1. Data is `m_data_out` captured at edge j.
- Timeout: TIMEOUT WAIT cycles without `m_done` → RESP on the next cycle.
- Back-to-back turnaround (RESP end to next LAUNCH): GAP_CYC + 1 cycles minimum.
- `m_data_in` and `m_cs` are stable from LAUNCH through RESP; `m_cs` drops on entry to GAP.
- All outputs are registered; no combinational path from `req` or `m_done` to any output.

## Test plan
- Single request: after reset, req[2]=1, data=8'hA5, sel=1, master model returns 8'h3C after 20 cycles.
  - `m_start` pulses once; `m_cs`=4'b0010 and `m_data_in`=8'hA5 for the whole transaction.
  - `rsp_valid`=4'b0100, `rsp_data`=8'h3C, `rsp_err`=0.
- Round-robin fairness: req=4'b1111 held continuously.
  - Grants occur in order 0,1,2,3,0.
  - `m_cs` is low for ≥GAP_CYC cycles between each pair of transactions.
- Timeout: `m_done` never asserted, TIMEOUT=50.
  - `rsp_valid` pulses exactly 51 cycles after LAUNCH with `rsp_err`=1 and `rsp_data`=8'h00.
  - `m_cs` clears in GAP.
- Bad select: N_CS=3, req[0] with sel=3.
  - `m_start` and `m_cs` never assert.
  - `rsp_valid[0]` pulses with `rsp_err`=1 two cycles after `req`.
- Reset and edge cases:
  - Assert `rst` in WAIT: all outputs return to reset values immediately, and no `rsp_valid` follows.
  - After release, a pending req[1] is granted first (pointer = 0 and req[0] low).
  - `m_done` and timeout in the same cycle gives `rsp_err`=0.
